alu_seq_arbiter: RTL and testbench
==================================

# alu_seq_arbiter

Sequencer and round-robin arbiter that shares the single 8-bit ALU between two requesters. It accepts one operation at a time over a valid/ready handshake, drives the ALU operand and opcode lines, and handles the multi-cycle divide by tracking the ALU `busy` flag with a timeout. It returns each result with the requester id on a valid/ready response channel. It sits between the microprocessor's execute stage (requester 0) and auxiliary units such as address/loop logic (requester 1) on one side, and the ALU on the other.

## Interface
- `DIV_TIMEOUT`, 64: cycles allowed in WAIT_DIV before an error response is returned.
- `NOP_OP`, 6'b111111: opcode driven to the ALU whenever no operation is in flight.
- `clk`  in  1  system clock, rising edge.
- `clrn`  in  1  asynchronous reset, active-low.
- `req0_valid` / `req1_valid`  in  1  requester n presents an operation.
- `req0_ready` / `req1_ready`  out  1  requester n's operation is accepted this cycle.
- `req0_op` / `req1_op`  in  6  ALU opcode.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  8  operands.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_id`  out  1  id of the requester that issued the operation.
- `rsp_result`  out  8  result.
- `rsp_err`  out  1  illegal opcode, or divide timeout.
- `alu_a`, `alu_b`  out  8  ALU operands.
- `alu_op`  out  6  ALU opcode.
- `alu_result`  in  8  ALU result.
- `alu_busy`  in  1  ALU divide in progress.
- `seq_busy`  out  1  high whenever state is not IDLE.

## Operation
- **Legal opcodes:** 00, 01, 02, 03, 04, 08, 09, 0A, 0B, 10, 11 (hex). Opcode 03 is divide; all other legal opcodes are single-cycle. Any other opcode is illegal.
- **Latched registers:** `op_r`, `a_r`, `b_r`, `id_r`, `res_r`, `err_r`, `seen_busy`, `tmo_cnt` (6 bits), `rr_ptr`.
- **IDLE:**
  - Grant goes to the only valid requester. If both are valid, grant goes to `rr_ptr`.
  - `reqN_ready` is combinational, high only for the granted requester.
  - On acceptance: latch op/a/b/id, set `rr_ptr` to the other requester, go to ISSUE.
- **ISSUE:**
  - Illegal op: `res_r` = 8'h00, `err_r` = 1, go to RESP.
  - Single-cycle op: capture `alu_result` into `res_r`, `err_r` = 0, go to RESP.
  - Divide: clear `tmo_cnt` and `seen_busy`, go to WAIT_DIV.
- **WAIT_DIV:**
  - `tmo_cnt` increments every cycle.
  - `seen_busy` is set on the first cycle `alu_busy` = 1.
  - When `seen_busy` = 1 and `alu_busy` = 0: capture `alu_result`, `err_r` = 0, go to RESP.
  - When `tmo_cnt` reaches DIV_TIMEOUT-1 without completion: `res_r` = 8'hFF, `err_r` = 1, go to RESP.
  - If completion and timeout occur in the same cycle, completion wins.
- **RESP:** `rsp_valid` = 1, holding `res_r`, `err_r`, `id_r` stable. On `rsp_valid && rsp_ready`, go to IDLE.
- **ALU drive:**
  - `alu_a` = `a_r` and `alu_b` = `b_r` always.
  - `alu_op` = `op_r` in ISSUE and WAIT_DIV, except NOP_OP for an illegal op.
  - `alu_op` = NOP_OP in IDLE and RESP. This guarantees the ALU never re-triggers a divide.
- **Arbitration rules:** Requests arriving during ISSUE, WAIT_DIV or RESP are not accepted; requesters must hold valid and payload until ready. There is one operation in flight at most.

## Timing
- **Reset** (asynchronous, `clrn` low): state = IDLE, `rr_ptr` = 0, all registers = 0.
  - Outputs during reset: `rsp_valid` = 0, `rsp_id` = 0, `rsp_result` = 0, `rsp_err` = 0, `seq_busy` = 0, `alu_a` = `alu_b` = 0, `alu_op` = NOP_OP.
  - Reset mid-operation drops the operation with no response.
- **Single-cycle op:** accepted at edge T, result captured at T+1, `rsp_valid` high from T+1.
- **Divide:** `rsp_valid` rises one edge after the first cycle in which `alu_busy` is sampled low after having been sampled high.
- **Timeout:** `rsp_valid` rises exactly DIV_TIMEOUT cycles after entering WAIT_DIV.
- **Throughput:** minimum 3 cycles per operation with `rsp_ready` tied high (IDLE → ISSUE → RESP).
- **Response stall:** `rsp_valid` is held indefinitely while `rsp_ready` = 0. No new grant is issued during the stall.

## Test plan
- Reset, then req0 ADD a=8'h12, b=8'h34 -> ALU sees op 00 one cycle; `rsp_valid` at T+1 with result 8'h46, id 0, err 0.
- req0 and req1 both valid continuously with XOR ops -> grants alternate 0,1,0,1; first grant goes to 0 after reset.
- req1 DIV a=100, b=7 with a model ALU that is busy for 9 cycles -> result 8'h0E, id 1. `alu_op` returns to 6'h3F in RESP and the ALU does not restart the divide.
- DIV with `alu_busy` stuck at 0 -> after 64 cycles, result 8'hFF, err 1. Next request is accepted normally.
- Illegal op 6'h05 -> result 8'h00, err 1. `alu_op` stays 6'h3F throughout.
- `rsp_ready` held low for 10 cycles, with `clrn` pulsed low during a later divide -> response stays stable for the full stall; after reset, all outputs are at reset values and no stale response appears.

Source files
------------

// File: rtl/alu_seq_arbiter.sv
// Purpose: round-robin sequencer that shares one 8-bit ALU between two requesters, including the multi-cycle divide.
// Latency: a single-cycle op responds one edge after it is accepted; a divide responds one edge after busy falls, or DIV_TIMEOUT edges after entering the wait.
// Backpressure: only one op is in flight at a time; the response is held until rsp_ready, and no new grant is issued until it is taken.
module alu_seq_arbiter #(
  parameter int unsigned DIV_TIMEOUT = 64,
  parameter logic [5:0]  NOP_OP      = 6'b111111
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [5:0] req0_op,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [5:0] req1_op,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_result,
  output logic       rsp_err,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [5:0] alu_op,
  input  logic [7:0] alu_result,
  input  logic       alu_busy,
  output logic       seq_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DIV, S_RESP} state_t;

  localparam logic [5:0] DIV_OP   = 6'h03;
  localparam logic [5:0] TMO_LAST = 6'(DIV_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       id_q, id_d;
  logic [7:0] res_q, res_d;
  logic       err_q, err_d;
  logic       seen_busy_q, seen_busy_d;
  logic [5:0] tmo_cnt_q, tmo_cnt_d;
  logic       rr_ptr_q, rr_ptr_d;
  logic       grant0, grant1;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      6'h00, 6'h01, 6'h02, 6'h03, 6'h04,
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h10, 6'h11: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  // A lone requester wins outright; on contention the round-robin pointer decides.
  assign grant0 = req0_valid && (!req1_valid || !rr_ptr_q);
  assign grant1 = req1_valid && (!req0_valid ||  rr_ptr_q);

  // Next-state, register updates and handshake/ALU drive for the sequencer.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    res_d       = res_q;
    err_d       = err_q;
    seen_busy_d = seen_busy_q;
    tmo_cnt_d   = tmo_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp_valid   = 1'b0;
    alu_op      = NOP_OP;

    case (state_q)
      S_IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0 || grant1) begin
          op_d     = grant1 ? req1_op : req0_op;
          a_d      = grant1 ? req1_a  : req0_a;
          b_d      = grant1 ? req1_b  : req0_b;
          id_d     = grant1;
          rr_ptr_d = !grant1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!op_legal(op_q)) begin
          // Illegal ops never reach the ALU; it keeps seeing NOP.
          res_d   = 8'h00;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (op_q == DIV_OP) begin
          alu_op      = op_q;
          tmo_cnt_d   = 6'd0;
          seen_busy_d = 1'b0;
          state_d     = S_WAIT_DIV;
        end else begin
          alu_op  = op_q;
          res_d   = alu_result;
          err_d   = 1'b0;
          state_d = S_RESP;
        end
      end
      S_WAIT_DIV: begin
        alu_op      = op_q;
        tmo_cnt_d   = tmo_cnt_q + 6'd1;
        seen_busy_d = seen_busy_q | alu_busy;
        // Completion is tested first so it wins over a simultaneous timeout.
        if (seen_busy_q && !alu_busy) begin
          res_d   = alu_result;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (tmo_cnt_q == TMO_LAST) begin
          res_d   = 8'hFF;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched operation registers; reset drops any in-flight op.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= S_IDLE;
      op_q        <= 6'd0;
      a_q         <= 8'd0;
      b_q         <= 8'd0;
      id_q        <= 1'b0;
      res_q       <= 8'd0;
      err_q       <= 1'b0;
      seen_busy_q <= 1'b0;
      tmo_cnt_q   <= 6'd0;
      rr_ptr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      res_q       <= res_d;
      err_q       <= err_d;
      seen_busy_q <= seen_busy_d;
      tmo_cnt_q   <= tmo_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign rsp_err    = err_q;
  assign seq_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_seq_arbiter.sv
// Purpose: self-checking bench for alu_seq_arbiter with a small ALU model and a transaction-level reference.
// Latency: the reference predicts response timing per transaction in edges since acceptance.
// Backpressure: rsp_ready is driven by the stimulus, including a long stall.
module tb_alu_seq_arbiter;

  localparam int DIV_TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [5:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [7:0] rsp_result;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [5:0] alu_op;
  logic       alu_busy, seq_busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_seq_arbiter #(.DIV_TIMEOUT(DIV_TIMEOUT), .NOP_OP(6'h3F)) dut (
    .clk(clk), .clrn(clrn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_busy(alu_busy),
    .seq_busy(seq_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bench ALU arithmetic for the single-cycle opcodes.
  function automatic logic [7:0] alu_f(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      6'h00:   return a + b;
      6'h01:   return a - b;
      6'h02:   return a & b;
      6'h04:   return a | b;
      6'h08:   return a ^ b;
      6'h09:   return ~a;
      6'h0A:   return a << 1;
      6'h0B:   return a >> 1;
      6'h10:   return a + 8'd1;
      6'h11:   return a - 8'd1;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    logic [5:0] legal_list [11] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h10, 6'h11};
    foreach (legal_list[i]) if (legal_list[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // ALU model: a divide starts when opcode 03 first appears, then busy for busy_len cycles.
  int         busy_len = 9;
  int         div_starts = 0;
  logic [5:0] prev_op;
  int         div_left;
  logic [7:0] div_res;

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      prev_op  <= 6'h3F;
      div_left <= 0;
      div_res  <= 8'h00;
    end else begin
      prev_op <= alu_op;
      if (alu_op == 6'h03 && prev_op != 6'h03) begin
        div_starts <= div_starts + 1;
        div_left   <= busy_len;
        div_res    <= alu_a / alu_b;
      end else if (div_left > 0) begin
        div_left <= div_left - 1;
      end
    end
  end

  assign alu_busy   = (div_left > 0);
  assign alu_result = (alu_op == 6'h03) ? div_res : alu_f(alu_op, alu_a, alu_b);

  // Reference: one transaction in flight, its expected result and the edge count until it is offered.
  bit         m_inflight, m_rr, m_id, m_err;
  int         m_age, m_exp_age;
  logic [5:0] m_op;
  logic [7:0] m_a, m_b, m_res;

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      m_inflight = 1'b0;
      m_rr       = 1'b0;
      m_a        = 8'h00;
      m_b        = 8'h00;
      m_op       = 6'h3F;
      m_age      = 0;
      m_exp_age  = 0;
    end else if (m_inflight) begin
      if (m_age >= m_exp_age && rsp_ready) m_inflight = 1'b0;
      else m_age++;
    end else if (req0_valid || req1_valid) begin
      m_id       = (req0_valid && req1_valid) ? m_rr : req1_valid;
      m_op       = m_id ? req1_op : req0_op;
      m_a        = m_id ? req1_a : req0_a;
      m_b        = m_id ? req1_b : req0_b;
      m_rr       = !m_id;
      m_inflight = 1'b1;
      m_age      = 0;
      if (!is_legal(m_op)) begin
        m_res = 8'h00; m_err = 1'b1; m_exp_age = 1;
      end else if (m_op == 6'h03) begin
        if (busy_len > 0) begin
          m_res = m_a / m_b; m_err = 1'b0; m_exp_age = busy_len + 2;
        end else begin
          m_res = 8'hFF; m_err = 1'b1; m_exp_age = 1 + DIV_TIMEOUT;
        end
      end else begin
        m_res = alu_f(m_op, m_a, m_b); m_err = 1'b0; m_exp_age = 1;
      end
    end
  end

  // Every cycle: compare all DUT outputs against the reference (or reset values while clrn is low).
  always @(negedge clk) begin
    bit         exp_rv, exp_r0, exp_r1;
    logic [5:0] exp_op;
    if (!clrn) begin
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_seq_busy", seq_busy, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_op", alu_op, 6'h3F);
    end else begin
      exp_rv = m_inflight && (m_age >= m_exp_age);
      exp_r0 = !m_inflight && req0_valid && (!req1_valid || !m_rr);
      exp_r1 = !m_inflight && req1_valid && (!req0_valid || m_rr);
      exp_op = (m_inflight && !exp_rv && is_legal(m_op)) ? m_op : 6'h3F;
      chk("rsp_valid", rsp_valid, exp_rv);
      if (exp_rv) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_result", rsp_result, m_res);
        chk("rsp_err", rsp_err, m_err);
      end
      chk("seq_busy", seq_busy, m_inflight);
      chk("req0_ready", req0_ready, exp_r0);
      chk("req1_ready", req1_ready, exp_r1);
      chk("alu_op", alu_op, exp_op);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input bit id, input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
    bit done = 1'b0;
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    for (int i = 0; i < 100 && !done; i++) begin
      #1;
      done = id ? req1_ready : req0_ready;
      step();
    end
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
    chk("accept_wait", done, 1);
  endtask

  task automatic get_rsp(output logic id, output logic [7:0] res, output logic err);
    bit got = 1'b0;
    id = 1'b0; res = 8'h00; err = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      #1;
      if (rsp_valid && rsp_ready) begin
        got = 1'b1; id = rsp_id; res = rsp_result; err = rsp_err;
      end
      step();
    end
    chk("rsp_wait", got, 1);
  endtask

  task automatic reset_pulse();
    clrn = 1'b0;
    step(); step();
    clrn = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_chk, n_err);
    $fatal(1);
  end

  initial begin
    logic       id, err, g, got;
    logic [7:0] res;
    int         s;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    rsp_ready  = 1'b1;
    clrn       = 1'b0;
    step(); step();
    clrn = 1'b1;
    step();

    // ADD 12+34
    issue(0, 6'h00, 8'h12, 8'h34);
    get_rsp(id, res, err);
    chk("add_result", res, 8'h46); chk("add_id", id, 0); chk("add_err", err, 0);

    // Contending XOR streams alternate starting with requester 0
    reset_pulse();
    req0_op = 6'h08; req0_a = 8'h0F; req0_b = 8'hF0;
    req1_op = 6'h08; req1_a = 8'h33; req1_b = 8'h0F;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0; g = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        #1;
        if (req0_ready || req1_ready) begin got = 1'b1; g = req1_ready; end
        step();
      end
      chk("arb_wait", got, 1);
      chk("arb_grant", g, k % 2);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    get_rsp(id, res, err);
    chk("arb_last_result", res, 8'h3C); chk("arb_last_id", id, 1);

    // Divide 100/7 with a 9-cycle busy ALU, started exactly once
    busy_len = 9;
    s = div_starts;
    issue(1, 6'h03, 8'd100, 8'd7);
    get_rsp(id, res, err);
    chk("div_result", res, 8'h0E); chk("div_id", id, 1); chk("div_err", err, 0);
    repeat (5) step();
    chk("div_single_start", div_starts - s, 1);

    // Divide with busy stuck low times out, then a normal op follows
    busy_len = 0;
    issue(0, 6'h03, 8'd50, 8'd5);
    get_rsp(id, res, err);
    chk("tmo_result", res, 8'hFF); chk("tmo_err", err, 1);
    issue(1, 6'h00, 8'h01, 8'h02);
    get_rsp(id, res, err);
    chk("post_tmo_result", res, 8'h03); chk("post_tmo_err", err, 0);
    busy_len = 9;

    // Illegal opcode
    issue(0, 6'h05, 8'h09, 8'h09);
    get_rsp(id, res, err);
    chk("illegal_result", res, 8'h00); chk("illegal_err", err, 1);

    // Response stall for 10 cycles with requester 1 waiting
    rsp_ready = 1'b0;
    issue(0, 6'h08, 8'h0F, 8'hF0);
    req1_valid = 1'b1; req1_op = 6'h00; req1_a = 8'h20; req1_b = 8'h22;
    step();
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("stall_hold", {rsp_valid, rsp_err, rsp_result}, {1'b1, 1'b0, 8'hFF});
      chk("stall_no_grant", {req0_ready, req1_ready}, 2'b00);
      step();
    end
    rsp_ready = 1'b1;
    get_rsp(id, res, err);
    chk("stall_result", res, 8'hFF); chk("stall_id", id, 0);
    issue(1, 6'h00, 8'h20, 8'h22);
    get_rsp(id, res, err);
    chk("after_stall_result", res, 8'h42); chk("after_stall_id", id, 1);

    // Reset in the middle of a divide drops it silently
    issue(1, 6'h03, 8'd200, 8'd10);
    repeat (3) step();
    reset_pulse();
    #1;
    chk("post_rst_valid", rsp_valid, 0);
    chk("post_rst_busy", seq_busy, 0);
    chk("post_rst_op", alu_op, 6'h3F);
    repeat (15) step();
    issue(1, 6'h00, 8'h05, 8'h06);
    get_rsp(id, res, err);
    chk("fresh_result", res, 8'h0B); chk("fresh_id", id, 1);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
